// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator scheduler and its timer.
package elevator_pkg;

    localparam int FLOOR_W = 3;
    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DOOR = 2'b11
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/elevator_timer.sv
// Tick-gated up-counter shared by the move and door phases. done pulses in
// the tick cycle that reaches the limit; the count wraps to zero that cycle.
module elevator_timer
    import elevator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               clear,
    input  logic [TIMER_W-1:0] limit,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    // clear wins over a terminal count so a restarted phase never ends early
    assign done = tick && !clear && (count == limit - TIMER_W'(1));

    // counter register: advances only on tick, restarts on clear or done
    always_ff @(posedge clk) begin
        if (rst || clear || done) begin
            count <= '0;
        end else if (tick) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-style elevator scheduler: latches floor calls, picks a direction,
// steps between floors on the shared timer and holds the door open.
//   state   | meaning
//   IDLE    | stopped, door closed, evaluates pending calls
//   UP      | travelling toward the nearest pending floor above
//   DOWN    | travelling toward the nearest pending floor below
//   DOOR    | stopped at current_floor with the door open
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 16,
    parameter int DOOR_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [1:0]            sim_state,
    output logic [7:0]            destination,
    output logic [2:0]            current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    state_t               state, state_n;
    dir_t                 dir, dir_n;
    logic [FLOOR_W-1:0]   floor_n, step, up_tgt, dn_tgt;
    logic [NUM_FLOORS-1:0] call_mask, clr_mask, cur_bit, step_bit;
    logic                 up_any, dn_any, ahead_any;
    logic                 timer_clear, t_done;
    logic [TIMER_W-1:0]   limit;

    assign sim_state = state;
    assign busy      = (state != ST_IDLE);
    assign cur_bit   = NUM_FLOORS'(1) << current_floor;
    assign step      = (state == ST_UP) ? current_floor + FLOOR_W'(1)
                                        : current_floor - FLOOR_W'(1);
    assign step_bit  = NUM_FLOORS'(1) << step;
    assign ahead_any = (state == ST_UP) ? up_any : dn_any;
    assign limit     = (state == ST_DOOR) ? TIMER_W'(DOOR_CYCLES) : TIMER_W'(MOVE_CYCLES);

    elevator_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clear (timer_clear),
        .limit (limit),
        .done  (t_done)
    );

    // nearest pending floor strictly above and strictly below current_floor
    always_comb begin
        up_any = 1'b0;
        dn_any = 1'b0;
        up_tgt = current_floor;
        dn_tgt = current_floor;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                up_any = 1'b1;
                up_tgt = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                dn_any = 1'b1;
                dn_tgt = FLOOR_W'(i);
            end
        end
    end

    // target shown on the display: next stop while moving, else where we are
    always_comb begin
        case (state)
            ST_UP:   destination = {5'b0, up_tgt};
            ST_DOWN: destination = {5'b0, dn_tgt};
            default: destination = {5'b0, current_floor};
        endcase
    end

    // next-state, direction, floor and call-latch masks
    always_comb begin
        state_n     = state;
        dir_n       = dir;
        floor_n     = current_floor;
        timer_clear = 1'b0;
        call_mask   = call_req;
        clr_mask    = '0;
        case (state)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if ((call_req & cur_bit) != '0) begin
                    call_mask = call_req & ~cur_bit;
                    state_n   = ST_DOOR;
                end else if ((pending & cur_bit) != '0) begin
                    clr_mask = cur_bit;
                    state_n  = ST_DOOR;
                end else if (pending != '0) begin
                    if ((dir == DIR_UP && up_any) || (dir == DIR_DOWN && !dn_any)) begin
                        state_n = ST_UP;
                        dir_n   = DIR_UP;
                    end else begin
                        state_n = ST_DOWN;
                        dir_n   = DIR_DOWN;
                    end
                end
            end
            ST_UP, ST_DOWN: begin
                // never step without a pending floor ahead, which keeps the
                // car inside the served range
                if (!ahead_any) begin
                    timer_clear = 1'b1;
                    state_n     = ST_IDLE;
                end else if (t_done) begin
                    floor_n = step;
                    if ((pending & step_bit) != '0) begin
                        clr_mask  = step_bit;
                        call_mask = call_req & ~step_bit;
                        state_n   = ST_DOOR;
                    end
                end
            end
            ST_DOOR: begin
                if ((call_req & cur_bit) != '0) begin
                    call_mask   = call_req & ~cur_bit;
                    timer_clear = 1'b1;
                end else if (t_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // state, direction, floor and pending-call registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            dir           <= DIR_UP;
            current_floor <= '0;
            pending       <= '0;
        end else begin
            state         <= state_n;
            dir           <= dir_n;
            current_floor <= floor_n;
            pending       <= (pending | call_mask) & ~clr_mask;
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler with MOVE_CYCLES=2, DOOR_CYCLES=3.
// Every change of (sim_state, current_floor), plus explicit probes, pops one
// expected record holding outputs and the cycle distance from the last change.
module tb_elevator_scheduler;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_DOWN = 2'b10;
    localparam logic [1:0] S_DOOR = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic [7:0] call_req = '0;
    logic [1:0] sim_state;
    logic [7:0] destination;
    logic [2:0] current_floor;
    logic [7:0] pending;
    logic       busy;

    elevator_scheduler #(
        .NUM_FLOORS  (8),
        .MOVE_CYCLES (2),
        .DOOR_CYCLES (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .call_req      (call_req),
        .sim_state     (sim_state),
        .destination   (destination),
        .current_floor (current_floor),
        .pending       (pending),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [2:0] fl;
        logic [7:0] dst;
        logic [7:0] pnd;
        int         dly;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;
    logic probe  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ev(input logic [1:0] st, input int fl, input int dst, input int pnd, input int dly);
        exp_t e;
        e.st  = st;
        e.fl  = 3'(fl);
        e.dst = 8'(dst);
        e.pnd = 8'(pnd);
        e.dly = dly;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input logic [1:0] st, input int fl);
        int n;
        n = 0;
        while (!(sim_state == st && current_floor == 3'(fl))) begin
            step();
            n++;
            if (n > 300) begin
                total++;
                $display("FAIL wait_for: state=%0d floor=%0d, required state=%0d floor=%0d", sim_state, current_floor, st, fl);
                break;
            end
        end
    endtask

    // monitor: pop and compare on every state/floor change or probe request
    logic       armed = 1'b0;
    logic [1:0] prev_st;
    logic [2:0] prev_fl;
    int         last_cyc;
    always @(negedge clk) begin
        exp_t e;
        logic changed;
        logic ok;
        int   dly;
        if (mon_en) begin
            if (!armed) begin
                armed    = 1'b1;
                last_cyc = cyc;
                prev_st  = sim_state;
                prev_fl  = current_floor;
            end
            changed = (sim_state != prev_st) || (current_floor != prev_fl);
            if (changed || probe) begin
                dly = cyc - last_cyc;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_event: st=%0d fl=%0d dst=%0d pnd=%h, queue empty",
                             sim_state, current_floor, destination, pending);
                end else begin
                    e  = sb.pop_front();
                    ok = (sim_state == e.st) && (current_floor == e.fl) &&
                         (destination == e.dst) && (pending == e.pnd) &&
                         (busy == (e.st != S_IDLE)) && (e.dly < 0 || dly == e.dly);
                    if (ok) passed++;
                    else $display("FAIL event%0d: got st=%0d fl=%0d dst=%0d pnd=%h busy=%0b dly=%0d, want st=%0d fl=%0d dst=%0d pnd=%h busy=%0b dly=%0d",
                                  total, sim_state, current_floor, destination, pending, busy, dly,
                                  e.st, e.fl, e.dst, e.pnd, (e.st != S_IDLE), e.dly);
                end
                if (changed) last_cyc = cyc;
            end
            prev_st = sim_state;
            prev_fl = current_floor;
        end
    end

    initial begin
        repeat (3) step();

        // reset values, then a single call to floor 5 from floor 0
        rst      = 1'b0;
        call_req = 8'h20;
        probe    = 1'b1;
        mon_en   = 1'b1;
        ev(S_IDLE, 0, 0, 8'h00, -1);
        ev(S_UP,   0, 5, 8'h20, 2);
        ev(S_UP,   1, 5, 8'h20, 2);
        ev(S_UP,   2, 5, 8'h20, 2);
        ev(S_UP,   3, 5, 8'h20, 2);
        ev(S_UP,   4, 5, 8'h20, 2);
        ev(S_DOOR, 5, 5, 8'h00, 2);
        ev(S_IDLE, 5, 5, 8'h00, 3);
        step();
        call_req = '0;
        probe    = 1'b0;
        wait_for(S_IDLE, 5);

        // call at current floor while idle, then again mid-door to restart it
        ev(S_DOOR, 5, 5, 8'h00, 1);
        ev(S_IDLE, 5, 5, 8'h00, 5);
        call_req = 8'h20;
        step();
        call_req = '0;
        step();
        call_req = 8'h20;
        step();
        call_req = '0;
        wait_for(S_IDLE, 5);

        // reset mid-door with calls and tick asserted in the reset cycle
        ev(S_DOOR, 5, 5, 8'h00, 1);
        ev(S_IDLE, 0, 0, 8'h00, 2);
        call_req = 8'h20;
        step();
        call_req = '0;
        step();
        rst      = 1'b1;
        call_req = 8'hFF;
        step();
        rst      = 1'b0;

        // up toward 7, closer call to 3 preempts, resume, reverse to 4 and 2
        call_req = 8'h80;
        ev(S_UP, 0, 7, 8'h80, 2);
        ev(S_UP, 1, 7, 8'h80, 2);
        step();
        call_req = '0;
        wait_for(S_UP, 1);
        ev(S_UP,   1, 3, 8'h88, -1);
        ev(S_UP,   2, 3, 8'h88, 2);
        ev(S_DOOR, 3, 3, 8'h80, 2);
        ev(S_IDLE, 3, 3, 8'h80, 3);
        ev(S_UP,   3, 7, 8'h80, 1);
        ev(S_UP,   4, 7, 8'h80, 2);
        ev(S_UP,   5, 7, 8'h94, 2);
        ev(S_UP,   6, 7, 8'h94, 12);
        ev(S_DOOR, 7, 7, 8'h14, 2);
        ev(S_IDLE, 7, 7, 8'h14, 3);
        ev(S_DOWN, 7, 4, 8'h14, 1);
        ev(S_DOWN, 6, 4, 8'h14, 2);
        ev(S_DOWN, 5, 4, 8'h14, 2);
        ev(S_DOOR, 4, 4, 8'h04, 2);
        ev(S_IDLE, 4, 4, 8'h04, 3);
        ev(S_DOWN, 4, 2, 8'h04, 1);
        ev(S_DOWN, 3, 2, 8'h04, 2);
        ev(S_DOOR, 2, 2, 8'h00, 2);
        ev(S_IDLE, 2, 2, 8'h00, 3);
        call_req = 8'h08;
        step();
        call_req = '0;
        probe    = 1'b1;
        step();
        probe    = 1'b0;
        wait_for(S_UP, 4);
        call_req = 8'h14;
        step();
        call_req = '0;
        wait_for(S_UP, 5);
        step();
        tick = 1'b0;
        repeat (10) step();
        tick = 1'b1;
        wait_for(S_IDLE, 2);
        repeat (5) step();

        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: %0d expected events left, required 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
